// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold: a winner keeps the shared resource until
// it signals Done, drops its request, or its tenure reaches MAX_HOLD cycles.
module rr_hold_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] Req,
  input  logic [NUM_REQ-1:0] Done,
  output logic [NUM_REQ-1:0] Grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [ID_W-1:0]      r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]      r_gid, w_gid_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_to, w_to_nxt;

  logic                 w_any;
  logic [ID_W-1:0]      w_win;
  logic                 w_own_done;
  logic                 w_own_req;
  logic                 w_expired;
  logic                 w_release;

  // Walk downward so the lowest offset from r_ptr is the last (winning) write.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (Req[idx]) begin
        w_any = 1'b1;
        w_win = ID_W'(idx);
      end
    end
  end

  assign w_own_done = Done[r_gid];
  assign w_own_req  = Req[r_gid];
  assign w_expired  = (r_cnt == CNT_W'(MAX_HOLD));
  assign w_release  = w_own_done | ~w_own_req | w_expired;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gid_nxt   = r_gid;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_to_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (w_any) begin
          w_state_nxt = OWN;
          w_grant_nxt = NUM_REQ'(1) << w_win;
          w_gid_nxt   = w_win;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      OWN: begin
        if (w_release) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = (r_gid == ID_W'(NUM_REQ - 1)) ? '0 : r_gid + ID_W'(1);
          // A clean release in the expiry cycle suppresses the timeout pulse.
          w_to_nxt    = w_expired & w_own_req & ~w_own_done;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gid   <= w_gid_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign Grant       = r_grant;
  assign grant_id    = r_gid;
  assign busy        = r_busy;
  assign timeout_err = r_to;

endmodule
